// File: rtl/multichannel_decimator.sv
// -----------------------------------------------------------------------------
// multichannel_decimator
//
// Purpose:
//   NCH independent clock decimators. Each channel synchronises its own enable
//   into the clkin domain, then produces a registered strobe every ratio+1
//   clkin cycles, with the first strobe delayed by a programmable phase.
//   A channel either runs continuously (burst_len = 0) or emits exactly
//   burst_len strobes, flags the last one with done, and parks in HOLD until
//   its enable is released.
//
//   All state changes on the falling edge of clkin. Strobe is therefore
//   constant across every high phase of clkin, so decimated = strobe & clkin
//   is a clean gated clock with no runt pulses.
//
// Ports:
//   clkin      in   1            clock, all registers use its falling edge
//   reset      in   1            asynchronous, active-high reset
//   enable     in   NCH          per-channel run request (asynchronous)
//   ratio      in   NCH*CTR_W    divide value, period = ratio+1 cycles
//   phase      in   NCH*CTR_W    start-to-first-strobe delay in cycles
//   burst_len  in   NCH*BURST_W  strobes per burst, 0 = continuous
//   strobe     out  NCH          registered one-cycle decimated tick
//   decimated  out  NCH          gated clock, strobe & clkin
//   busy       out  NCH          high while the channel is in RUN
//   done       out  NCH          pulse coincident with the last burst strobe
// -----------------------------------------------------------------------------
module multichannel_decimator #(
  parameter int NCH         = 4,
  parameter int CTR_W       = 8,
  parameter int BURST_W     = 8,
  parameter int SYNC_STAGES = 3   // must be at least 2
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic [NCH-1:0]         enable,
  input  logic [NCH*CTR_W-1:0]   ratio,
  input  logic [NCH*CTR_W-1:0]   phase,
  input  logic [NCH*BURST_W-1:0] burst_len,
  output logic [NCH-1:0]         strobe,
  output logic [NCH-1:0]         decimated,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch

      // ---------------------------------------------------------------------
      // Enable synchroniser. Bit 0 takes the raw asynchronous input; the
      // top bit is the only one the FSM is allowed to look at.
      // ---------------------------------------------------------------------
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   en_s;

      always_ff @(negedge clkin or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], enable[gi]};
        end
      end

      assign en_s = sync_q[SYNC_STAGES-1];

      // ---------------------------------------------------------------------
      // Channel configuration slices and start-up values.
      // ---------------------------------------------------------------------
      logic [CTR_W-1:0]   ratio_in;
      logic [CTR_W-1:0]   phase_in;
      logic [BURST_W-1:0] burst_in;
      logic [CTR_W-1:0]   cnt_start_d;

      assign ratio_in = ratio[gi*CTR_W +: CTR_W];
      assign phase_in = phase[gi*CTR_W +: CTR_W];
      assign burst_in = burst_len[gi*BURST_W +: BURST_W];

      // The phase only seeds the down-counter at start, so it is never held
      // in a register of its own. Clamping to ratio keeps the first strobe
      // no later than one full period after start.
      assign cnt_start_d = (phase_in < ratio_in) ? phase_in : ratio_in;

      // ---------------------------------------------------------------------
      // Channel FSM with registered outputs.
      // ---------------------------------------------------------------------
      state_t             state_q;
      logic [CTR_W-1:0]   ratio_q;
      logic [BURST_W-1:0] burst_q;
      logic [CTR_W-1:0]   cnt_q;
      logic [BURST_W-1:0] pcnt_q;
      logic               strobe_q;
      logic               busy_q;
      logic               done_q;

      logic [BURST_W-1:0] pcnt_d;
      logic               last_strobe_d;

      assign pcnt_d        = pcnt_q + BURST_W'(1);
      // In continuous mode (burst_q == 0) pcnt simply wraps and is ignored.
      assign last_strobe_d = (burst_q != '0) && (pcnt_d == burst_q);

      always_ff @(negedge clkin or posedge reset) begin
        if (reset) begin
          state_q  <= ST_IDLE;
          ratio_q  <= '0;
          burst_q  <= '0;
          cnt_q    <= '0;
          pcnt_q   <= '0;
          strobe_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              strobe_q <= 1'b0;
              done_q   <= 1'b0;
              busy_q   <= 1'b0;
              if (en_s) begin
                // Configuration is sampled only here; later changes on the
                // inputs wait for the next start.
                ratio_q <= ratio_in;
                burst_q <= burst_in;
                cnt_q   <= cnt_start_d;
                pcnt_q  <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_RUN;
              end
            end

            ST_RUN: begin
              if (!en_s) begin
                // Abandon the run; a partial burst never raises done.
                strobe_q <= 1'b0;
                done_q   <= 1'b0;
                busy_q   <= 1'b0;
                state_q  <= ST_IDLE;
              end else if (cnt_q == '0) begin
                strobe_q <= 1'b1;
                cnt_q    <= ratio_q;
                pcnt_q   <= pcnt_d;
                if (last_strobe_d) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_HOLD;
                end else begin
                  done_q  <= 1'b0;
                end
              end else begin
                strobe_q <= 1'b0;
                done_q   <= 1'b0;
                cnt_q    <= cnt_q - CTR_W'(1);
              end
            end

            ST_HOLD: begin
              // Burst finished: stay silent until enable is released, so a
              // new burst needs a fresh low-to-high enable.
              strobe_q <= 1'b0;
              done_q   <= 1'b0;
              busy_q   <= 1'b0;
              if (!en_s) begin
                state_q <= ST_IDLE;
              end
            end

            default: begin
              strobe_q <= 1'b0;
              done_q   <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end
          endcase
        end
      end

      assign strobe[gi]    = strobe_q;
      assign busy[gi]      = busy_q;
      assign done[gi]      = done_q;
      // strobe_q only moves while clkin is low, so the AND cannot glitch.
      assign decimated[gi] = strobe_q & clkin;
    end
  endgenerate

endmodule

// File: tb/tb_multichannel_decimator.sv
`timescale 1ns/100ps
module tb_multichannel_decimator;
  localparam int NCH     = 4;
  localparam int CTR_W   = 8;
  localparam int BURST_W = 8;
  localparam int SYNC    = 3;

  logic                   clkin = 1'b0;
  logic                   reset = 1'b1;
  logic [NCH-1:0]         enable = '0;
  logic [NCH*CTR_W-1:0]   ratio = '0;
  logic [NCH*CTR_W-1:0]   phase = '0;
  logic [NCH*BURST_W-1:0] burst_len = '0;
  logic [NCH-1:0]         strobe, decimated, busy, done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  multichannel_decimator #(
    .NCH(NCH), .CTR_W(CTR_W), .BURST_W(BURST_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clkin(clkin), .reset(reset), .enable(enable), .ratio(ratio),
    .phase(phase), .burst_len(burst_len), .strobe(strobe),
    .decimated(decimated), .busy(busy), .done(done)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works in absolute cycle numbers. A channel started at
  // cycle t0 strobes at t0 + 1 + min(P,R) + k*(R+1); the k-th strobe (1-based)
  // of a burst of length B ends the burst when k == B.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] hist_q[$];
  int             m_mode[NCH];      // 0 idle, 1 running, 2 finished burst
  int             m_t0[NCH], m_r[NCH], m_p[NCH], m_b[NCH];
  int             ncyc;
  logic [NCH-1:0] exp_strobe = '0, exp_busy = '0, exp_done = '0;
  logic [NCH-1:0] m_en;
  int             m_d, m_k, m_off;

  always @(negedge clkin or posedge reset) begin
    if (reset) begin
      hist_q.delete();
      ncyc = 0;
      exp_strobe = '0; exp_busy = '0; exp_done = '0;
      for (int i = 0; i < NCH; i++) m_mode[i] = 0;
    end else begin
      ncyc++;
      hist_q.push_back(enable);
      // The enable seen by a channel is the one sampled SYNC edges earlier.
      m_en = (hist_q.size() > SYNC) ? hist_q[hist_q.size()-1-SYNC] : '0;
      while (hist_q.size() > SYNC + 1) void'(hist_q.pop_front());
      for (int i = 0; i < NCH; i++) begin
        exp_strobe[i] = 1'b0;
        exp_done[i]   = 1'b0;
        if (m_mode[i] == 0) begin
          exp_busy[i] = 1'b0;
          if (m_en[i]) begin
            m_mode[i] = 1;
            m_t0[i]   = ncyc;
            m_r[i]    = int'(ratio[i*CTR_W +: CTR_W]);
            m_p[i]    = int'(phase[i*CTR_W +: CTR_W]);
            m_b[i]    = int'(burst_len[i*BURST_W +: BURST_W]);
            exp_busy[i] = 1'b1;
          end
        end else if (m_mode[i] == 1) begin
          if (!m_en[i]) begin
            m_mode[i]   = 0;
            exp_busy[i] = 1'b0;
          end else begin
            m_off = (m_p[i] < m_r[i]) ? m_p[i] : m_r[i];
            m_d   = ncyc - m_t0[i] - 1 - m_off;
            if (m_d >= 0 && (m_d % (m_r[i] + 1)) == 0) begin
              m_k = m_d / (m_r[i] + 1) + 1;
              exp_strobe[i] = 1'b1;
              if (m_b[i] != 0 && m_k == m_b[i]) begin
                exp_done[i] = 1'b1;
                exp_busy[i] = 1'b0;
                m_mode[i]   = 2;
              end
            end
          end
        end else begin
          exp_busy[i] = 1'b0;
          if (!m_en[i]) m_mode[i] = 0;
        end
      end
    end
  end

  // Continuous comparison against the model, mid high phase and mid low phase.
  always @(posedge clkin) begin
    #2;
    if (chk_en && !reset) begin
      check("model strobe", strobe, exp_strobe);
      check("model busy", busy, exp_busy);
      check("model done", done, exp_done);
      check("decimated high phase", decimated, exp_strobe);
    end
  end

  always @(negedge clkin) begin
    #2;
    if (chk_en && !reset) check("decimated low phase", decimated, '0);
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clkin);
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic set_ch(input int ch, input int r, input int p, input int b);
    ratio[ch*CTR_W +: CTR_W]         = CTR_W'(r);
    phase[ch*CTR_W +: CTR_W]         = CTR_W'(p);
    burst_len[ch*BURST_W +: BURST_W] = BURST_W'(b);
  endtask

  task automatic wait_busy(input int ch, output bit found);
    found = 1'b0;
    for (int w = 0; w < 20; w++) begin
      cyc();
      if (busy[ch]) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Samples once per cycle starting at the current sample (index 0).
  task automatic measure(input int ch, input int win, output int cnt, output int first,
                         output int gmin, output int gmax, output int ndone, output int doneidx);
    int last, g;
    cnt = 0; first = -1; gmin = 0; gmax = 0; ndone = 0; doneidx = -1; last = -1;
    for (int c = 0; c <= win; c++) begin
      if (c > 0) cyc();
      if (strobe[ch]) begin
        if (last >= 0) begin
          g = c - last;
          if (cnt == 1) begin gmin = g; gmax = g; end
          else begin
            if (g < gmin) gmin = g;
            if (g > gmax) gmax = g;
          end
        end else begin
          first = c;
        end
        last = c;
        cnt++;
      end
      if (done[ch]) begin
        ndone++;
        doneidx = strobe[ch] ? cnt : -2;
      end
    end
  endtask

  typedef struct {
    int ch; int r; int p; int b;
    int exp_first; int exp_count; int exp_gap;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit found;
    int cnt, first, gmin, gmax, ndone, doneidx, win, k, extra;
    int lastc[NCH], cmin[NCH], cmax[NCH], ccnt[NCH];

    // ch, ratio, phase, burst | cycles start->first strobe, strobes, spacing
    tbl[0] = '{0,   3, 0, 4, 1, 4,   4};
    tbl[1] = '{1,   4, 2, 3, 3, 3,   5};
    tbl[2] = '{2,   0, 0, 5, 1, 5,   1};
    tbl[3] = '{3,   2, 7, 2, 3, 2,   3};
    tbl[4] = '{0,   5, 5, 1, 6, 1,   0};
    tbl[5] = '{1, 255, 0, 2, 1, 2, 256};

    // Reset state
    cyc(); cyc();
    check("reset strobe", strobe, '0);
    check("reset busy", busy, '0);
    check("reset done", done, '0);
    check("reset decimated", decimated, '0);
    reset = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Table-driven single-channel bursts
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ratio = '0; phase = '0; burst_len = '0; enable = '0;
      set_ch(tbl[r].ch, tbl[r].r, tbl[r].p, tbl[r].b);
      enable[tbl[r].ch] = 1'b1;
      wait_busy(tbl[r].ch, found);
      check($sformatf("row%0d busy_rise", r), 32'(found), 1);
      if (found) begin
        win = tbl[r].exp_first + (tbl[r].exp_count - 1) * tbl[r].exp_gap + 12;
        measure(tbl[r].ch, win, cnt, first, gmin, gmax, ndone, doneidx);
        check($sformatf("row%0d first", r), first, tbl[r].exp_first);
        check($sformatf("row%0d count", r), cnt, tbl[r].exp_count);
        check($sformatf("row%0d gap_min", r), gmin, tbl[r].exp_gap);
        check($sformatf("row%0d gap_max", r), gmax, tbl[r].exp_gap);
        check($sformatf("row%0d done_count", r), ndone, 1);
        check($sformatf("row%0d done_at_strobe", r), doneidx, tbl[r].exp_count);
        check($sformatf("row%0d busy_in_hold", r), 32'(busy[tbl[r].ch]), 0);
      end
      enable = '0;
      repeat (SYNC + 2) cyc();
    end

    // Channel 0 continuous, ratio change ignored, then stop mid-period
    do_reset();
    ratio = '0; phase = '0; burst_len = '0; enable = '0;
    set_ch(0, 7, 0, 0);
    enable[0] = 1'b1;
    wait_busy(0, found);
    check("stop busy_rise", 32'(found), 1);
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      cyc();
      if (strobe[0]) found = 1'b1;
    end
    check("stop first strobe seen", 32'(found), 1);
    set_ch(0, 1, 0, 0);
    measure(0, 26, cnt, first, gmin, gmax, ndone, doneidx);
    check("stop count after ratio change", cnt, 4);
    check("stop gap_min after ratio change", gmin, 8);
    check("stop gap_max after ratio change", gmax, 8);
    enable[0] = 1'b0;
    k = 0; extra = 0;
    for (int w = 1; w <= 20; w++) begin
      cyc();
      if (strobe[0]) extra++;
      if (done[0]) ndone++;
      if (!busy[0]) begin k = w; break; end
    end
    check("stop busy fall delay", k, SYNC + 1);
    repeat (10) begin
      cyc();
      if (strobe[0]) extra++;
      if (done[0]) ndone++;
    end
    check("stop strobes after drop", extra, 0);
    check("stop no done", ndone, 0);

    // Channel 1 burst, hold, restart
    do_reset();
    ratio = '0; phase = '0; burst_len = '0; enable = '0;
    set_ch(1, 4, 2, 3);
    for (int b = 0; b < 2; b++) begin
      enable[1] = 1'b1;
      wait_busy(1, found);
      check($sformatf("burst%0d busy_rise", b), 32'(found), 1);
      measure(1, 40, cnt, first, gmin, gmax, ndone, doneidx);
      check($sformatf("burst%0d count", b), cnt, 3);
      check($sformatf("burst%0d done", b), ndone, 1);
      check($sformatf("burst%0d spacing", b), gmin, 5);
      enable[1] = 1'b0;
      repeat (SYNC + 3) cyc();
    end

    // All channels together, then reset mid-run
    do_reset();
    phase = '0; burst_len = '0; enable = '0;
    for (int i = 0; i < NCH; i++) set_ch(i, i + 1, 0, 0);
    enable = '1;
    wait_busy(0, found);
    check("multi busy all", 32'(busy), 32'hF);
    for (int i = 0; i < NCH; i++) begin lastc[i] = -1; cmin[i] = 1000; cmax[i] = 0; ccnt[i] = 0; end
    for (int c = 0; c < 40; c++) begin
      cyc();
      for (int i = 0; i < NCH; i++) begin
        if (strobe[i]) begin
          if (lastc[i] >= 0) begin
            if (c - lastc[i] < cmin[i]) cmin[i] = c - lastc[i];
            if (c - lastc[i] > cmax[i]) cmax[i] = c - lastc[i];
          end
          lastc[i] = c;
          ccnt[i]++;
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("multi ch%0d period min", i), cmin[i], i + 2);
      check($sformatf("multi ch%0d period max", i), cmax[i], i + 2);
    end
    // Channel 0 (ratio 1) strobes every other cycle; wait until it is high
    found = 1'b0;
    for (int w = 0; w < 4 && !found; w++) begin
      if (strobe[0]) found = 1'b1; else cyc();
    end
    check("multi strobe0 before reset", 32'(found), 1);
    reset = 1'b1;
    #1;
    check("async reset strobe", strobe, '0);
    check("async reset decimated", decimated, '0);
    check("async reset busy", busy, '0);
    check("async reset done", done, '0);
    cyc();
    reset = 1'b0;
    extra = 0;
    for (int w = 0; w < SYNC + 1; w++) begin
      cyc();
      if (strobe != '0) extra++;
    end
    check("no strobe while resyncing", extra, 0);
    check("busy after resync", 32'(busy), 32'hF);
    enable = '0;
    repeat (SYNC + 2) cyc();

    // Randomised traffic checked against the model
    do_reset();
    enable = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCH; i++) begin
        set_ch(i, $urandom_range(0, 9), $urandom_range(0, 12), $urandom_range(0, 4));
        if ($urandom_range(0, 15) == 0) enable[i] = ~enable[i];
      end
      if (c == 300) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
